// File: rtl/mem_arbiter_if.sv
// Signal bundle between the I/D cache miss logic, the shared memory port and mem_arbiter.
// slave = the arbiter itself; master = the caches and memory instance around it.
interface mem_arbiter_if;
  logic        i_fill_req;
  logic [15:0] i_fill_addr;
  logic        d_fill_req;
  logic [15:0] d_fill_addr;
  logic        d_wr_req;
  logic [15:0] d_wr_addr;
  logic [15:0] d_wr_data;

  logic [15:0] mem_addr;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_data_in;
  logic        mem_data_valid;
  logic [15:0] mem_data_out;

  logic        fill_word_valid;
  logic        fill_dest;
  logic [15:0] fill_word_addr;
  logic [15:0] fill_word_data;
  logic        i_fill_done;
  logic        d_fill_done;
  logic        d_wr_ack;

  modport slave (
    input  i_fill_req, i_fill_addr, d_fill_req, d_fill_addr,
           d_wr_req, d_wr_addr, d_wr_data, mem_data_valid, mem_data_out,
    output mem_addr, mem_enable, mem_wr, mem_data_in,
           fill_word_valid, fill_dest, fill_word_addr, fill_word_data,
           i_fill_done, d_fill_done, d_wr_ack
  );

  modport master (
    output i_fill_req, i_fill_addr, d_fill_req, d_fill_addr,
           d_wr_req, d_wr_addr, d_wr_data, mem_data_valid, mem_data_out,
    input  mem_addr, mem_enable, mem_wr, mem_data_in,
           fill_word_valid, fill_dest, fill_word_addr, fill_word_data,
           i_fill_done, d_fill_done, d_wr_ack
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fixed-priority sequencer for the shared main-memory port: I fill > D fill > D write-through.
// Fills stream WORDS reads and steer returned words back to the owning cache.
module mem_arbiter #(
  parameter int MEM_LATENCY = 4,
  parameter int WORDS       = 8
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  localparam logic [4:0] ISSUE_END = 5'(WORDS);
  localparam logic [3:0] LAST_R    = 4'(WORDS - 1);

  // Completion is driven by returned words, so latency only needs to be sane, not counted.
  if (MEM_LATENCY < 1 || WORDS < 1 || WORDS > 16) begin : g_param_check
    $error("mem_arbiter: MEM_LATENCY must be >= 1 and WORDS in 1..16");
  end

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic [15:0] addr_q,  addr_d;
  logic [15:0] data_q,  data_d;
  logic [4:0]  k_q,     k_d;
  logic [3:0]  r_q,     r_d;

  logic        in_fill, in_write, issuing, last_word;
  logic [15:0] base;

  assign in_fill   = (state_q == S_FILL);
  assign in_write  = (state_q == S_WRITE);
  assign issuing   = in_fill && (k_q < ISSUE_END);
  assign base      = {addr_q[15:4], 4'h0};
  assign last_word = in_fill && bus.mem_data_valid && (r_q == LAST_R);

  // NOTE: every next-state variable gets its hold value first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    data_d  = data_q;
    k_d     = k_q;
    r_d     = r_q;
    case (state_q)
      S_IDLE: begin
        k_d = '0;
        r_d = '0;
        if (bus.i_fill_req) begin
          state_d = S_FILL;
          owner_d = 1'b0;
          addr_d  = bus.i_fill_addr;
        end else if (bus.d_fill_req) begin
          state_d = S_FILL;
          owner_d = 1'b1;
          addr_d  = bus.d_fill_addr;
        end else if (bus.d_wr_req) begin
          state_d = S_WRITE;
          owner_d = 1'b1;
          addr_d  = bus.d_wr_addr;
          data_d  = bus.d_wr_data;
        end
      end
      S_FILL: begin
        if (issuing) k_d = k_q + 5'd1;
        if (bus.mem_data_valid) r_d = r_q + 4'd1;
        if (last_word) state_d = S_IDLE;
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      k_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      k_q     <= k_d;
      r_q     <= r_d;
    end
  end

  assign bus.mem_enable  = issuing | in_write;
  assign bus.mem_wr      = in_write;
  assign bus.mem_addr    = issuing  ? base + {10'd0, k_q, 1'b0} :
                           in_write ? addr_q : 16'h0000;
  assign bus.mem_data_in = in_write ? data_q : 16'h0000;

  // Returned words are only meaningful while a fill owns the port; anything else is dropped.
  assign bus.fill_word_valid = in_fill & bus.mem_data_valid;
  assign bus.fill_dest       = in_fill & owner_q;
  assign bus.fill_word_addr  = in_fill ? base + {11'd0, r_q, 1'b0} : 16'h0000;
  assign bus.fill_word_data  = bus.fill_word_valid ? bus.mem_data_out : 16'h0000;

  assign bus.i_fill_done = last_word & ~owner_q;
  assign bus.d_fill_done = last_word &  owner_q;
  assign bus.d_wr_ack    = in_write;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a timeline model predicts every output per cycle from the grant rules,
// a 4-cycle memory model answers reads, and directed then random requests exercise the arbiter.
module tb_mem_arbiter;
  localparam int NC    = 2048;
  localparam int WORDS = 8;
  localparam int LAT   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.MEM_LATENCY(LAT), .WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory: read data appears LAT cycles after the enable cycle; contents are a fixed hash.
  typedef struct packed { logic v; logic [15:0] a; } rd_t;
  rd_t         pipe [LAT] = '{default: '0};
  logic        inject = 1'b0;
  logic [15:0] inject_data = 16'h0000;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return a ^ 16'h5A5A ^ {a[7:0], a[15:8]};
  endfunction

  always @(posedge clk) begin
    pipe[0] <= '{v: bus.mem_enable & ~bus.mem_wr, a: bus.mem_addr};
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign bus.mem_data_valid = pipe[LAT-1].v | inject;
  assign bus.mem_data_out   = inject ? inject_data : mem_fn(pipe[LAT-1].a);

  // Expected outputs for each cycle; an all-zero entry is the idle picture.
  typedef struct packed {
    logic busy, en, wr, fv, fdest, idone, ddone, ack;
    logic [15:0] addr, din, faddr, fdata;
  } exp_t;
  exp_t exp_q [NC];

  int cyc = 0;
  int idle_from = 0;
  int i_drop = -1, d_drop = -1, w_drop = -1;
  int checks = 0, failures = 0;
  bit chk_on = 1'b0;

  task automatic clear_from(input int c);
    for (int i = c; i < NC; i++) exp_q[i] = '0;
  endtask

  task automatic grant_fill(input int t, input logic dest, input logic [15:0] a);
    logic [15:0] base, wa;
    base = a & 16'hFFF0;
    for (int c = t + 1; c <= t + LAT + WORDS; c++) exp_q[c].busy = 1'b1;
    for (int k = 0; k < WORDS; k++) begin
      wa = base + 16'(2 * k);
      exp_q[t+1+k].en         = 1'b1;
      exp_q[t+1+k].addr       = wa;
      exp_q[t+1+LAT+k].fv     = 1'b1;
      exp_q[t+1+LAT+k].fdest  = dest;
      exp_q[t+1+LAT+k].faddr  = wa;
      exp_q[t+1+LAT+k].fdata  = mem_fn(wa);
    end
    if (dest) exp_q[t+LAT+WORDS].ddone = 1'b1;
    else      exp_q[t+LAT+WORDS].idone = 1'b1;
    idle_from = t + LAT + WORDS + 1;
    if (dest) d_drop = idle_from;
    else      i_drop = idle_from;
  endtask

  task automatic grant_write(input int t, input logic [15:0] a, input logic [15:0] d);
    exp_q[t+1].busy = 1'b1;
    exp_q[t+1].en   = 1'b1;
    exp_q[t+1].wr   = 1'b1;
    exp_q[t+1].addr = a;
    exp_q[t+1].din  = d;
    exp_q[t+1].ack  = 1'b1;
    idle_from = t + 2;
    w_drop = idle_from;
  endtask

  // Grant rules: reset wins; otherwise an idle port serves I fill, then D fill, then write.
  task automatic model_cycle();
    if (rst) begin
      clear_from(cyc + 1);
      idle_from = cyc + 1;
      i_drop = -1; d_drop = -1; w_drop = -1;
    end else if (cyc >= idle_from) begin
      if (bus.i_fill_req)      grant_fill(cyc, 1'b0, bus.i_fill_addr);
      else if (bus.d_fill_req) grant_fill(cyc, 1'b1, bus.d_fill_addr);
      else if (bus.d_wr_req)   grant_write(cyc, bus.d_wr_addr, bus.d_wr_data);
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    e = exp_q[cyc];
    chk("mem_enable",  16'(bus.mem_enable),      16'(e.en));
    chk("mem_wr",      16'(bus.mem_wr),          16'(e.wr));
    chk("fill_valid",  16'(bus.fill_word_valid), 16'(e.fv));
    chk("i_fill_done", 16'(bus.i_fill_done),     16'(e.idone));
    chk("d_fill_done", 16'(bus.d_fill_done),     16'(e.ddone));
    chk("d_wr_ack",    16'(bus.d_wr_ack),        16'(e.ack));
    if (!e.busy || e.en) chk("mem_addr",    bus.mem_addr,    e.addr);
    if (!e.busy || e.wr) chk("mem_data_in", bus.mem_data_in, e.din);
    if (!e.busy || e.fv) begin
      chk("fill_dest",      16'(bus.fill_dest),  16'(e.fdest));
      chk("fill_word_addr", bus.fill_word_addr,  e.faddr);
      chk("fill_word_data", bus.fill_word_data,  e.fdata);
    end
  endtask

  // One clock: predict, compare mid-cycle, then advance and let finished requesters drop.
  task automatic step();
    model_cycle();
    @(negedge clk);
    if (chk_on) check_outputs();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc == i_drop) bus.i_fill_req = 1'b0;
    if (cyc == d_drop) bus.d_fill_req = 1'b0;
    if (cyc == w_drop) bus.d_wr_req   = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    clear_from(0);
    rst             = 1'b1;
    bus.i_fill_req  = 1'b0; bus.i_fill_addr = '0;
    bus.d_fill_req  = 1'b0; bus.d_fill_addr = '0;
    bus.d_wr_req    = 1'b0; bus.d_wr_addr   = '0; bus.d_wr_data = '0;
    @(posedge clk);
    #1;

    // Reset: from the cycle after rst is sampled, everything reads zero.
    step();
    chk_on = 1'b1;
    step();
    rst = 1'b0;
    run(2);

    // Single I fill at 1234: block 1230..123E, fill_dest 0, done on the 8th word.
    bus.i_fill_addr = 16'h1234; bus.i_fill_req = 1'b1;
    run(16);

    // All three at once: I burst, then D burst, then the write.
    bus.i_fill_addr = 16'h2468; bus.i_fill_req = 1'b1;
    bus.d_fill_addr = 16'h8ACE; bus.d_fill_req = 1'b1;
    bus.d_wr_addr   = 16'h0100; bus.d_wr_data  = 16'h1111; bus.d_wr_req = 1'b1;
    run(32);

    // Lone write-through.
    bus.d_wr_addr = 16'h0040; bus.d_wr_data = 16'hBEEF; bus.d_wr_req = 1'b1;
    run(4);

    // D fill in the top block: FFF0..FFFE without carry.
    bus.d_fill_addr = 16'hFFFA; bus.d_fill_req = 1'b1;
    run(16);

    // Request withdrawn mid-burst: burst and done still complete.
    bus.d_fill_addr = 16'h3337; bus.d_fill_req = 1'b1;
    run(3);
    bus.d_fill_req = 1'b0;
    run(14);

    // Reset at T+6 of an I burst, stray returns afterwards, then a fresh fill.
    bus.i_fill_addr = 16'h5550; bus.i_fill_req = 1'b1;
    run(6);
    rst = 1'b1; bus.i_fill_req = 1'b0;
    step();
    rst = 1'b0;
    run(10);
    bus.i_fill_addr = 16'h777C; bus.i_fill_req = 1'b1;
    run(16);

    // Spurious read data while idle.
    inject_data = 16'hDEAD; inject = 1'b1;
    run(3);
    inject = 1'b0;
    run(2);

    // Random traffic: idle requesters raise new requests with random addresses and data.
    for (int n = 0; n < 600; n++) begin
      if (!bus.i_fill_req && $urandom_range(7) == 0) begin
        bus.i_fill_addr = 16'($urandom); bus.i_fill_req = 1'b1;
      end
      if (!bus.d_fill_req && $urandom_range(7) == 0) begin
        bus.d_fill_addr = 16'($urandom); bus.d_fill_req = 1'b1;
      end
      if (!bus.d_wr_req && $urandom_range(5) == 0) begin
        bus.d_wr_addr = 16'($urandom); bus.d_wr_data = 16'($urandom); bus.d_wr_req = 1'b1;
      end
      step();
    end
    run(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
